// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: sequences mul/div start, pipeline stall and a single HI/LO write per op
module md_issue_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [1:0] ex_op,
  input  logic       ex_div_zero,
  input  logic       flush,
  input  logic       pipe_hold,
  input  logic       div_done,
  output logic       mul_start,
  output logic       div_start,
  output logic       md_signed,
  output logic       stall,
  output logic       hilo_wena,
  output logic [1:0] hilo_sel,
  output logic       busy,
  output logic       err_timeout
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic is_div, is_div_n, nowrite, nowrite_n, md_signed_n, err_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      nowrite     <= 1'b0;
      md_signed   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      is_div      <= is_div_n;
      nowrite     <= nowrite_n;
      md_signed   <= md_signed_n;
      err_timeout <= err_n;
    end
  end
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    is_div_n    = is_div;
    nowrite_n   = nowrite;
    md_signed_n = md_signed;
    err_n       = err_timeout;
    mul_start   = 1'b0;
    div_start   = 1'b0;
    stall       = 1'b0;
    hilo_wena   = 1'b0;
    hilo_sel    = 2'b00;
    case (state)
      IDLE: if (ex_valid && !flush) begin
        stall       = 1'b1;
        is_div_n    = ex_op[1];
        md_signed_n = ~ex_op[0];
        nowrite_n   = ex_op[1] & ex_div_zero;
        if (!ex_op[1]) begin
          mul_start = 1'b1;
          cnt_n     = 8'(MUL_CYCLES - 1);
          state_n   = MUL;
        end else if (ex_div_zero) begin
          state_n = WB;
        end else begin
          div_start = 1'b1;
          cnt_n     = '0;
          state_n   = DIV;
        end
      end
      MUL: if (flush) state_n = IDLE;
      else begin
        stall   = 1'b1;
        cnt_n   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
        state_n = (cnt == 8'd0) ? WB : MUL;
      end
      DIV: if (flush) state_n = IDLE;
      else begin
        stall = 1'b1;
        cnt_n = cnt + 8'd1;
        // a completion in the timeout cycle still counts as a normal result
        if (div_done) state_n = WB;
        else if (cnt == 8'(DIV_TIMEOUT - 1)) begin
          err_n     = 1'b1;
          nowrite_n = 1'b1;
          state_n   = WB;
        end
      end
      WB: begin
        hilo_sel = is_div ? 2'b10 : 2'b01;
        if (flush) state_n = IDLE;
        else begin
          stall     = pipe_hold;
          hilo_wena = ~pipe_hold & ~nowrite;
          state_n   = pipe_hold ? WB : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized and directed checks against a per-transaction timeline model
module tb_md_issue_ctrl;
  localparam int MC = 4;
  localparam int DT = 40;
  logic clk = 1'b0;
  logic rst, ex_valid, ex_div_zero, flush, pipe_hold, div_done;
  logic [1:0] ex_op;
  logic mul_start, div_start, md_signed, stall, hilo_wena, busy, err_timeout;
  logic [1:0] hilo_sel;
  int vectors = 0;
  int errors = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MUL_CYCLES(MC), .DIV_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_div_zero(ex_div_zero),
    .flush(flush), .pipe_hold(pipe_hold), .div_done(div_done), .mul_start(mul_start),
    .div_start(div_start), .md_signed(md_signed), .stall(stall), .hilo_wena(hilo_wena),
    .hilo_sel(hilo_sel), .busy(busy), .err_timeout(err_timeout)
  );

  // One instruction offered at t=0; d = cycle of the div_done pulse (outside 1..DT means never in time),
  // hold = WB cycles with pipe_hold, f = flush cycle (-1 for none).
  task automatic run_op(input logic [1:0] op, input logic dz, input int d, input int hold, input int f);
    logic is_div, tmo, nw;
    int w, last, pulses, exp_pulses;
    logic [5:0] exp, act;
    is_div = op[1];
    tmo = is_div && !dz && !(d >= 1 && d <= DT);
    w = 1 + (!is_div ? MC : (dz ? 0 : (tmo ? DT : d)));
    nw = is_div && (dz || tmo);
    last = (f >= 1 && f <= w + hold) ? f : w + hold;
    exp_pulses = ((f >= 1 && f <= w + hold) || nw) ? 0 : 1;
    pulses = 0;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      ex_valid = 1'b1;
      ex_op = op;
      ex_div_zero = (t == 0) ? dz : ~dz;
      div_done = is_div && t >= 1 && t == d;
      pipe_hold = (t >= w && t < w + hold);
      flush = (t == f);
      #1;
      if (tmo && t == DT + 1 && !(f >= 1 && f <= DT)) exp_err = 1'b1;
      exp = (t == 0) ? {~op[1], op[1] & ~dz, 1'b1, 1'b0, 1'b0, exp_err}
          : (t == f) ? {4'b0000, 1'b1, exp_err}
          : (t < w)  ? {2'b00, 1'b1, 1'b0, 1'b1, exp_err}
          : {2'b00, t < w + hold, (t == w + hold) && !nw, 1'b1, exp_err};
      act = {mul_start, div_start, stall, hilo_wena, busy, err_timeout};
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL op%0d t=%0d {mstart,dstart,stall,wena,busy,err}: got %b expected %b", op, t, act, exp);
      end
      if (hilo_wena === 1'b1) pulses++;
      if (t >= w && t != f) begin
        vectors++;
        if ({hilo_sel, md_signed} !== {is_div ? 2'b10 : 2'b01, ~op[0]}) begin
          errors++;
          $display("FAIL wb_sel op%0d t=%0d {sel,signed}: got %b expected %b", op, t,
                   {hilo_sel, md_signed}, {is_div ? 2'b10 : 2'b01, ~op[0]});
        end
      end
    end
    vectors++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL wena_count op%0d: got %0d expected %0d", op, pulses, exp_pulses);
    end
  endtask

  task automatic idle_check(input logic dd);
    @(negedge clk);
    {ex_valid, flush, pipe_hold, ex_div_zero} = 4'b0;
    div_done = dd;
    #1;
    vectors++;
    if ({mul_start, div_start, stall, hilo_wena, busy, err_timeout, hilo_sel} !== {5'b0, exp_err, 2'b00}) begin
      errors++;
      $display("FAIL idle: got %b expected %b",
               {mul_start, div_start, stall, hilo_wena, busy, err_timeout, hilo_sel}, {5'b0, exp_err, 2'b00});
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    {ex_valid, flush, pipe_hold, ex_div_zero, div_done} = 5'b0;
    ex_op = 2'b00;
    exp_err = 1'b0;
    #1;
    vectors++;
    if ({mul_start, div_start, md_signed, stall, hilo_wena, hilo_sel, busy, err_timeout} !== 9'b0) begin
      errors++;
      $display("FAIL reset: got %b expected %b",
               {mul_start, div_start, md_signed, stall, hilo_wena, hilo_sel, busy, err_timeout}, 9'b0);
    end
  endtask

  task automatic test_mul;
    run_op(2'b00, 1'b0, 0, 0, -1);
    idle_check(1'b0);
    run_op(2'b01, 1'b0, 0, 0, -1);
    idle_check(1'b0);
  endtask

  task automatic test_div;
    run_op(2'b11, 1'b0, 17, 0, -1);
    idle_check(1'b0);
    run_op(2'b10, 1'b0, 1, 0, -1);
    idle_check(1'b0);
    run_op(2'b10, 1'b1, 5, 0, -1);
    idle_check(1'b0);
  endtask

  task automatic test_timeout;
    run_op(2'b10, 1'b0, DT, 0, -1);
    idle_check(1'b0);
    run_op(2'b10, 1'b0, 0, 0, -1);
    idle_check(1'b1);
    run_op(2'b00, 1'b0, 0, 0, -1);
    idle_check(1'b0);
  endtask

  task automatic test_flush;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_op = 2'b00;
    flush = 1'b1;
    {pipe_hold, div_done, ex_div_zero} = 3'b0;
    #1;
    vectors++;
    if ({mul_start, div_start, stall, hilo_wena, busy} !== 5'b0) begin
      errors++;
      $display("FAIL idle_flush: got %b expected %b", {mul_start, div_start, stall, hilo_wena, busy}, 5'b0);
    end
    idle_check(1'b0);
    run_op(2'b00, 1'b0, 0, 0, 2);
    idle_check(1'b0);
    run_op(2'b11, 1'b0, 9, 0, 4);
    idle_check(1'b0);
    idle_check(1'b1);
    run_op(2'b01, 1'b0, 0, 2, MC + 2);
    idle_check(1'b0);
  endtask

  task automatic test_hold;
    run_op(2'b00, 1'b0, 0, 3, -1);
    idle_check(1'b0);
    run_op(2'b10, 1'b1, 0, 2, -1);
    idle_check(1'b0);
  endtask

  task automatic test_back_to_back;
    run_op(2'b00, 1'b0, 0, 0, -1);
    run_op(2'b11, 1'b0, 3, 1, -1);
    run_op(2'b10, 1'b1, 0, 0, -1);
    run_op(2'b01, 1'b0, 0, 0, -1);
    idle_check(1'b0);
  endtask

  task automatic test_rst_mid_div;
    @(negedge clk);
    ex_valid = 1'b1;
    ex_op = 2'b10;
    {ex_div_zero, flush, pipe_hold, div_done} = 4'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_valid = 1'b0;
    div_done = 1'b1;
    exp_err = 1'b0;
    #1;
    vectors++;
    if ({mul_start, div_start, md_signed, stall, hilo_wena, hilo_sel, busy, err_timeout} !== 9'b0) begin
      errors++;
      $display("FAIL rst_mid_div: got %b expected %b",
               {mul_start, div_start, md_signed, stall, hilo_wena, hilo_sel, busy, err_timeout}, 9'b0);
    end
    idle_check(1'b0);
  endtask

  task automatic test_random;
    int r, d, f;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      d = (r == 0) ? 0 : (r == 1) ? DT : (r == 2) ? DT + 1 : $urandom_range(1, 25);
      f = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : -1;
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, d, $urandom_range(0, 3), f);
      if ($urandom_range(0, 1) == 1) idle_check(1'($urandom_range(0, 1)));
    end
    idle_check(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    {ex_valid, flush, pipe_hold, ex_div_zero, div_done} = 5'b0;
    ex_op = 2'b00;
    test_reset;
    test_mul;
    test_div;
    test_flush;
    test_hold;
    test_back_to_back;
    test_timeout;
    test_rst_mid_div;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
